// File: rtl/led_pkg.sv
// Shared types and default constants for the LED activity stretcher/dimmer.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIT  = 2'd1,
    HOLD = 2'd2
  } led_state_t;

  // 50 ms of on-time at the fixed 160 MHz LED clock.
  localparam int LED_STRETCH_160M = 8_000_000;
  localparam int LED_PWM_BITS     = 4;

  // Hold-counter width; a one-cycle stretch still needs a 1-bit register.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// One LED channel: two-flop synchronizer, IDLE/LIT/HOLD stretch FSM and hold counter.
// Exposes the look-ahead activity bit so the top can register it alongside led_on.
module led_stretch_ch
  import led_pkg::*;
#(
  parameter int STRETCH_CYCLES = LED_STRETCH_160M
) (
  input  logic clock,
  input  logic resn,
  input  logic led_in,
  output logic active_next
);

  localparam int                CNT_W  = cnt_width(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(STRETCH_CYCLES - 1);

  logic             sync_q1;
  logic             s;
  led_state_t       state;
  led_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // NOTE: sequential state uses non-blocking assignments so both synchronizer
  // stages sample the pre-edge values and form a true two-flop chain.
  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      sync_q1 <= 1'b0;
      s       <= 1'b0;
    end else begin
      sync_q1 <= led_in;
      s       <= sync_q1;
    end
  end

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_next = LIT;
          cnt_next   = RELOAD;
        end
      end
      LIT: begin
        cnt_next = RELOAD;
        if (!s) state_next = HOLD;
      end
      HOLD: begin
        // Re-trigger wins over expiry; the counter is never decremented at zero.
        if (s) begin
          state_next = LIT;
          cnt_next   = RELOAD;
        end else if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Look-ahead decode lets the top register active in the same stage as the FSM.
  always_comb begin
    active_next = (state_next != IDLE);
  end

  a_lit_reload : assert property (@(posedge clock) disable iff (!resn)
    (state == LIT) |-> (cnt == RELOAD));

  a_hold_dec : assert property (@(posedge clock) disable iff (!resn)
    (state == HOLD && !s && cnt != '0) |=> (cnt == $past(cnt) - CNT_W'(1)));

  a_hold_expire : assert property (@(posedge clock) disable iff (!resn)
    (state == HOLD && !s && cnt == '0) |=> (state == IDLE));

endmodule

// File: rtl/led_stretch.sv
// Per-LED activity stretcher and global PWM dimmer driving active-high and active-low pins.
// Define LED_STRETCH_PWM_EN to build the PWM counter and brightness capture; otherwise led_on = active.
module led_stretch
  import led_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int STRETCH_CYCLES = LED_STRETCH_160M,
  parameter int PWM_BITS       = LED_PWM_BITS
) (
  input  logic                clock,
  input  logic                resn,
  input  logic [WIDTH-1:0]    led_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [WIDTH-1:0]    led_on,
  output logic [WIDTH-1:0]    led_n,
  output logic [WIDTH-1:0]    active
);

  logic [WIDTH-1:0] active_next;
  logic             pwm_gate_next;
  logic [WIDTH-1:0] led_on_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    led_stretch_ch #(
      .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_ch (
      .clock       (clock),
      .resn        (resn),
      .led_in      (led_in[i]),
      .active_next (active_next[i])
    );
  end

`ifdef LED_STRETCH_PWM_EN
  // Counter runs 0 .. 2^PWM_BITS-2 so all-ones brightness is always on.
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_cnt_next;
  logic [PWM_BITS-1:0] bri_q;
  logic [PWM_BITS-1:0] bri_next;

  always_comb begin
    pwm_cnt_next  = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
    bri_next      = (pwm_cnt == '0) ? brightness : bri_q;
    // Gate from next-cycle values so the registered led_on matches
    // active & (pwm_cnt < bri_q) in every cycle.
    pwm_gate_next = (pwm_cnt_next < bri_next);
  end

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      pwm_cnt <= '0;
      bri_q   <= '1;
    end else begin
      pwm_cnt <= pwm_cnt_next;
      bri_q   <= bri_next;
    end
  end

  a_pwm_range : assert property (@(posedge clock) disable iff (!resn)
    pwm_cnt <= PWM_LAST);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_gate_next     = 1'b1;
`endif

  assign led_on_next = active_next & {WIDTH{pwm_gate_next}};

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      active <= '0;
      led_on <= '0;
      led_n  <= '1;
    end else begin
      active <= active_next;
      led_on <= led_on_next;
      led_n  <= ~led_on_next;
    end
  end

  a_led_n_inverse : assert property (@(posedge clock) disable iff (!resn)
    led_n == ~led_on);

  a_on_implies_active : assert property (@(posedge clock) disable iff (!resn)
    (led_on & ~active) == '0);

endmodule
